// File: rtl/if_stage.sv
// Instruction-fetch stage feeding decode.
// Holds the fetch PC, reads a synchronous instruction ROM once per cycle, and
// presents Ins/PC/PC4/Valid to decode. Supports decode stall, redirect with a
// single-bubble flush, and a halt FSM that stops fetch on HALT_INS.
//
// Handshake: Valid=1 means Ins/PC/PC4 carry a real instruction. Decode accepts
// it on any rising edge where Stall=0; while Stall=1 every output holds
// unchanged. Redirect=1 takes priority over Stall and always flushes the
// presented slot (Valid drops for exactly one unstalled edge).
//
// The ROM array has no write port; its contents come from IMEM_FILE via the
// tool flow (or are written directly by a simulation environment).
module if_stage #(
  parameter int          IMEM_DEPTH = 1024,
  parameter              IMEM_FILE  = "imem.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INS   = 32'h0000_000C
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] Ins,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        Valid,
  output logic        Halted,
  output logic [31:0] InsCnt,
  output logic        state_dbg
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  logic [31:0]   rom [IMEM_DEPTH];
  logic [31:0]   rom_q;
  logic [AW-1:0] rd_idx;

  state_t      state_q, state_d;
  logic [31:0] issue_pc_q, issue_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        inflight_v_q, inflight_v_d;
  logic [31:0] ins_d, pc_d, pc4_d, cnt_d;
  logic        valid_d, halted_d;
  logic [31:0] target;

  // Word-aligned redirect target; the two low address bits are ignored.
  assign target    = RedirectPC & ~32'h3;
  assign state_dbg = state_q;

  // Synchronous ROM read, one access per cycle; address wraps modulo depth.
  always_ff @(posedge CLK) begin
    rom_q <= rom[rd_idx];
  end

  // Next-state and next-output logic for the fetch pipeline and halt FSM.
  always_comb begin
    state_d       = state_q;
    issue_pc_d    = issue_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_v_d  = inflight_v_q;
    ins_d         = Ins;
    pc_d          = PC;
    pc4_d         = PC4;
    valid_d       = Valid;
    halted_d      = Halted;
    rd_idx        = issue_pc_q[AW+1:2];
    cnt_d         = (Valid && !Stall) ? InsCnt + 32'd1 : InsCnt;

    case (state_q)
      S_RUN: begin
        if (Redirect) begin
          // Wrong-path flush: restart fetch at the target, drop the current slot.
          rd_idx        = target[AW+1:2];
          inflight_pc_d = target;
          inflight_v_d  = 1'b1;
          issue_pc_d    = target + 32'd4;
          ins_d         = '0;
          pc_d          = '0;
          pc4_d         = '0;
          valid_d       = 1'b0;
        end else if (Stall) begin
          // Re-read the in-flight address so rom_q still matches inflight_pc.
          rd_idx = inflight_pc_q[AW+1:2];
        end else begin
          rd_idx        = issue_pc_q[AW+1:2];
          inflight_pc_d = issue_pc_q;
          inflight_v_d  = 1'b1;
          issue_pc_d    = issue_pc_q + 32'd4;
          ins_d         = inflight_v_q ? rom_q : '0;
          pc_d          = inflight_pc_q;
          pc4_d         = inflight_pc_q + 32'd4;
          valid_d       = inflight_v_q;
          if (inflight_v_q && (rom_q == HALT_INS)) begin
            // Deliver the halt instruction, then stop advancing fetch.
            state_d       = S_HALT;
            inflight_v_d  = 1'b0;
            inflight_pc_d = inflight_pc_q;
            issue_pc_d    = issue_pc_q;
          end
        end
      end
      S_HALT: begin
        rd_idx       = inflight_pc_q[AW+1:2];
        inflight_v_d = 1'b0;
        if (!Stall) begin
          ins_d    = '0;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // State and output registers, cleared asynchronously on reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_RUN;
      issue_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_v_q  <= 1'b0;
      Ins           <= '0;
      PC            <= '0;
      PC4           <= '0;
      Valid         <= 1'b0;
      Halted        <= 1'b0;
      InsCnt        <= '0;
    end else begin
      state_q       <= state_d;
      issue_pc_q    <= issue_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_v_q  <= inflight_v_d;
      Ins           <= ins_d;
      PC            <= pc_d;
      PC4           <= pc4_d;
      Valid         <= valid_d;
      Halted        <= halted_d;
      InsCnt        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall, redirect, halt,
// and mid-stream reset, with hand-computed expected values.
module tb_if_stage;

  localparam logic [31:0] HALT = 32'h0000_000C;

  logic        CLK;
  logic        RST_N;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] Ins;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        Valid;
  logic        Halted;
  logic [31:0] InsCnt;
  logic        state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  if_stage dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Ins        (Ins),
    .PC         (PC),
    .PC4        (PC4),
    .Valid      (Valid),
    .Halted     (Halted),
    .InsCnt     (InsCnt),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_val(input int i);
    return 32'h5A00_0000 | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic fill_rom(input bit with_halt);
    for (int i = 0; i < 1024; i++) dut.rom[i] = rom_val(i);
    if (with_halt) dut.rom[2] = HALT;
  endtask

  // Sample 1 time unit after the active edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_and_load(input bit with_halt);
    @(posedge CLK);
    #1;
    RST_N      = 1'b0;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    fill_rom(with_halt);
    #2;
    check("rst_valid", {31'b0, Valid}, 32'd0);
    check("rst_ins", Ins, 32'd0);
    check("rst_cnt", InsCnt, 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;

    // T1: reset release and first fetches
    reset_and_load(1'b0);
    check("rst_pc", PC, 32'd0);
    check("rst_halted", {31'b0, Halted}, 32'd0);
    exp_q.push_back(rom_val(0));
    exp_q.push_back(rom_val(1));
    step();
    check("t1_e1_valid", {31'b0, Valid}, 32'd0);
    check("t1_e1_ins", Ins, 32'd0);
    step();
    e = exp_q.pop_front();
    check("t1_e2_ins", Ins, e);
    check("t1_e2_pc", PC, 32'd0);
    check("t1_e2_pc4", PC4, 32'd4);
    check("t1_e2_valid", {31'b0, Valid}, 32'd1);
    step();
    e = exp_q.pop_front();
    check("t1_e3_ins", Ins, e);
    check("t1_e3_pc", PC, 32'd4);
    check("t1_e3_cnt", InsCnt, 32'd1);

    // T2: stall three cycles while Ins=B
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_ins", Ins, rom_val(1));
      check("t2_hold_pc", PC, 32'd4);
      check("t2_hold_cnt", InsCnt, 32'd1);
    end
    Stall = 1'b0;
    step();
    check("t2_rel_ins", Ins, rom_val(2));
    check("t2_rel_pc", PC, 32'd8);
    check("t2_rel_cnt", InsCnt, 32'd2);

    // T3: redirect to 0x43 while Ins=C
    Redirect = 1'b1; RedirectPC = 32'h0000_0043;
    step();
    Redirect = 1'b0;
    check("t3_bubble_valid", {31'b0, Valid}, 32'd0);
    check("t3_bubble_ins", Ins, 32'd0);
    check("t3_cnt", InsCnt, 32'd3);
    step();
    check("t3_tgt_ins", Ins, rom_val(16));
    check("t3_tgt_pc", PC, 32'h40);
    check("t3_tgt_pc4", PC4, 32'h44);
    check("t3_tgt_valid", {31'b0, Valid}, 32'd1);
    step();
    check("t3_next_ins", Ins, rom_val(17));
    check("t3_next_pc", PC, 32'h44);

    // T4: redirect and stall together; redirect wins
    Redirect = 1'b1; Stall = 1'b1; RedirectPC = 32'h0000_0084;
    step();
    Redirect = 1'b0; Stall = 1'b0;
    check("t4_bubble_valid", {31'b0, Valid}, 32'd0);
    step();
    check("t4_tgt_ins", Ins, rom_val(33));
    check("t4_tgt_pc", PC, 32'h84);
    check("t4_cnt", InsCnt, 32'd4);
    // Out-of-range target wraps modulo ROM depth: 0x1004 -> index 1
    Redirect = 1'b1; RedirectPC = 32'h0000_1006;
    step();
    Redirect = 1'b0;
    check("t4_wrap_bubble", {31'b0, Valid}, 32'd0);
    step();
    check("t4_wrap_ins", Ins, rom_val(1));
    check("t4_wrap_pc", PC, 32'h1004);

    // T5: halt at PC=8, stalled in HALT, then redirects ignored
    reset_and_load(1'b1);
    step();
    step();
    check("t5_a", Ins, rom_val(0));
    step();
    check("t5_b", Ins, rom_val(1));
    step();
    check("t5_halt_ins", Ins, HALT);
    check("t5_halt_pc", PC, 32'd8);
    check("t5_halt_valid", {31'b0, Valid}, 32'd1);
    check("t5_halt_notyet", {31'b0, Halted}, 32'd0);
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t5_stall_ins", Ins, HALT);
      check("t5_stall_valid", {31'b0, Valid}, 32'd1);
      check("t5_stall_halted", {31'b0, Halted}, 32'd0);
    end
    Stall = 1'b0;
    step();
    check("t5_done_valid", {31'b0, Valid}, 32'd0);
    check("t5_done_ins", Ins, 32'd0);
    check("t5_done_halted", {31'b0, Halted}, 32'd1);
    check("t5_state", {31'b0, state_dbg}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      Redirect = 1'b1; RedirectPC = 32'h0000_0040;
      step();
      Redirect = 1'b0;
      step();
      check("t5_redir_valid", {31'b0, Valid}, 32'd0);
      check("t5_redir_halted", {31'b0, Halted}, 32'd1);
    end
    check("t5_cnt", InsCnt, 32'd3);

    // T6: asynchronous reset mid-stream at PC=0x20
    reset_and_load(1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (Valid && PC == 32'h20) break;
    end
    check("t6_reach_pc", PC, 32'h20);
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_async_valid", {31'b0, Valid}, 32'd0);
    check("t6_async_ins", Ins, 32'd0);
    check("t6_async_pc", PC, 32'd0);
    check("t6_async_cnt", InsCnt, 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step();
    check("t6_e1_valid", {31'b0, Valid}, 32'd0);
    step();
    check("t6_e2_ins", Ins, rom_val(0));
    check("t6_e2_pc", PC, 32'd0);
    check("t6_e2_cnt", InsCnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
